// File: rtl/univ_shift_pkg.sv
// univ_shift_pkg: op codes, FSM state encoding and op classification for the universal shift register
package univ_shift_pkg;
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_SHR  = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_LOAD = 3'b011;
   localparam logic [2:0] OP_ROR  = 3'b100;
   localparam logic [2:0] OP_ROL  = 3'b101;
   localparam logic [2:0] OP_ASR  = 3'b110;
   localparam logic [2:0] OP_CLR  = 3'b111;
   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;
   function automatic logic is_shift(input logic [2:0] op);
      return op inside {OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR};
   endfunction
endpackage

// File: rtl/univ_shift_step.sv
// univ_shift_step: one-bit-position next value for the shift/rotate ops
//   cur      current register value
//   op       operation code; non-shift codes pass cur through
//   sin_msb  fill bit entering the MSB on SHR
//   sin_lsb  fill bit entering the LSB on SHL
//   nxt      value after one step
module univ_shift_step
   import univ_shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] cur,
   input  logic [2:0]       op,
   input  logic             sin_msb,
   input  logic             sin_lsb,
   output logic [WIDTH-1:0] nxt
);
   always_comb begin
      nxt = op == OP_SHR ? {sin_msb, cur[WIDTH-1:1]} :
            op == OP_SHL ? {cur[WIDTH-2:0], sin_lsb} :
            op == OP_ROR ? {cur[0], cur[WIDTH-1:1]} :
            op == OP_ROL ? {cur[WIDTH-2:0], cur[WIDTH-1]} :
            op == OP_ASR ? {cur[WIDTH-1], cur[WIDTH-1:1]} : cur;
   end
endmodule

// File: rtl/univ_shift_reg_n.sv
// univ_shift_reg_n: universal shift register executing multi-bit shifts one bit per clock
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   cmd_valid  command request; cmd_ready high only while idle
//   op/amt     operation and distance, sampled on handshake (amt saturates at WIDTH)
//   data_in    parallel load value, sampled on handshake
//   sin_msb    SHR fill bit, sampled at every step edge
//   sin_lsb    SHL fill bit, sampled at every step edge
//   data_out   register contents; sout_lsb/sout_msb are its end bits
//   done       one-cycle pulse after the last edge of a command
module univ_shift_reg_n
   import univ_shift_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       op,
   input  logic [AW-1:0]    amt,
   input  logic [WIDTH-1:0] data_in,
   input  logic             sin_msb,
   input  logic             sin_lsb,
   output logic [WIDTH-1:0] data_out,
   output logic             sout_lsb,
   output logic             sout_msb,
   output logic             done
);
   logic             state;
   logic [AW-1:0]    rem;
   logic [AW-1:0]    amt_eff;
   logic [2:0]       op_r;
   logic [2:0]       step_op;
   logic [WIDTH-1:0] step_val;
   logic             multi;
   assign cmd_ready = state == ST_IDLE;
   assign amt_eff   = amt > AW'(WIDTH) ? AW'(WIDTH) : amt;
   assign multi     = is_shift(op) && amt_eff > AW'(1);
   // the accepting edge already performs the first step, so the live op drives it while idle
   assign step_op   = cmd_ready ? op : op_r;
   assign sout_lsb  = data_out[0];
   assign sout_msb  = data_out[WIDTH-1];
   univ_shift_step #(.WIDTH(WIDTH)) u_step (
      .cur     (data_out),
      .op      (step_op),
      .sin_msb (sin_msb),
      .sin_lsb (sin_lsb),
      .nxt     (step_val)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         rem      <= '0;
         op_r     <= OP_NOP;
         data_out <= '0;
         done     <= 1'b0;
      end else if (state == ST_RUN) begin
         data_out <= step_val;
         rem      <= rem - AW'(1);
         done     <= rem == AW'(1);
         if (rem == AW'(1)) state <= ST_IDLE;
      end else if (cmd_valid) begin
         op_r <= op;
         done <= !multi;
         if (op == OP_LOAD) data_out <= data_in;
         else if (op == OP_CLR) data_out <= '0;
         else if (is_shift(op) && amt_eff != '0) data_out <= step_val;
         if (multi) begin
            state <= ST_RUN;
            rem   <= amt_eff - AW'(1);
         end
      end else begin
         done <= 1'b0;
      end
   end
endmodule

// File: tb/tb_univ_shift_reg_n.sv
// tb_univ_shift_reg_n: scoreboard bench for univ_shift_reg_n with an arithmetic reference model
module tb_univ_shift_reg_n;
   localparam int W  = 8;
   localparam int AW = 4;
   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    op;
   logic [AW-1:0] amt;
   logic [W-1:0]  data_in;
   logic          sin_msb;
   logic          sin_lsb;
   logic [W-1:0]  data_out;
   logic          sout_lsb;
   logic          sout_msb;
   logic          done;
   int            checks = 0;
   int            errors = 0;
   int            done_cnt = 0;
   int            cmds = 0;
   logic [7:0]    exp_q[$];
   logic [7:0]    mdl = 8'h00;
   logic          sm_bits[16];
   logic          sl_bits[16];
   univ_shift_reg_n #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .op        (op),
      .amt       (amt),
      .data_in   (data_in),
      .sin_msb   (sin_msb),
      .sin_lsb   (sin_lsb),
      .data_out  (data_out),
      .sout_lsb  (sout_lsb),
      .sout_msb  (sout_msb),
      .done      (done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // result of n single-bit steps, expressed as plain integer arithmetic
   function automatic logic [7:0] model(input logic [2:0] o, input int n, input logic [7:0] v, input logic [7:0] din);
      int r;
      r = int'(v);
      case (o)
         3'd1: for (int i = 0; i < n; i++) r = (r >> 1) | (int'(sm_bits[i]) << 7);
         3'd2: for (int i = 0; i < n; i++) r = ((r << 1) | int'(sl_bits[i])) & 255;
         3'd3: r = int'(din);
         3'd4: r = ((r >> n) | (r << (8 - n))) & 255;
         3'd5: r = ((r << n) | (r >> (8 - n))) & 255;
         3'd6: r = r >= 128 ? ((r - 256) >>> n) & 255 : r >> n;
         3'd7: r = 0;
         default: ;
      endcase
      return r[7:0];
   endfunction
   always @(negedge clk) begin
      if (reset === 1'b1 && done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: done=1 expected no pending command at %0t", $time);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("result", data_out, e);
            chk("sout_lsb", sout_lsb, e[0]);
            chk("sout_msb", sout_msb, e[7]);
         end
      end
   end
   task automatic rand_bits();
      for (int i = 0; i < 16; i++) begin
         sm_bits[i] = 1'($urandom);
         sl_bits[i] = 1'($urandom);
      end
   endtask
   task automatic idle();
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask
   task automatic run_cmd(input logic [2:0] o, input int a, input logic [7:0] din, input bit inject, input int abort_at);
      int n;
      logic [7:0] e;
      n = (o inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) ? (a > 8 ? 8 : a) : 0;
      @(negedge clk);
      chk("ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      op        = o;
      amt       = AW'(a);
      data_in   = din;
      sin_msb   = sm_bits[0];
      sin_lsb   = sl_bits[0];
      e = model(o, n, mdl, din);
      exp_q.push_back(e);
      cmds++;
      @(posedge clk);
      for (int i = 1; i < n; i++) begin
         @(negedge clk);
         chk("busy_ready", cmd_ready, 0);
         chk("busy_done", done, 0);
         chk("step_data", data_out, model(o, i, mdl, din));
         sin_msb   = sm_bits[i];
         sin_lsb   = sl_bits[i];
         cmd_valid = inject;
         op        = 3'd7;
         data_in   = 8'($urandom);
         if (i == abort_at) begin
            #2 reset = 1'b0;
            #1;
            chk("abort_data", data_out, 0);
            chk("abort_ready", cmd_ready, 1);
            chk("abort_done", done, 0);
            void'(exp_q.pop_back());
            cmds--;
            mdl = 8'h00;
            cmd_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            return;
         end
         @(posedge clk);
      end
      mdl = e;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      reset = 1'b0; cmd_valid = 1'b0; op = 3'd0; amt = '0; data_in = '0; sin_msb = 1'b0; sin_lsb = 1'b0;
      rand_bits();
      repeat (2) @(negedge clk);
      chk("reset_data", data_out, 0);
      chk("reset_ready", cmd_ready, 1);
      chk("reset_done", done, 0);
      reset = 1'b1;
      run_cmd(3'd3, 0, 8'hA5, 0, 0);
      idle();
      chk("load_a5", data_out, 8'hA5);
      run_cmd(3'd5, 3, 8'h00, 0, 0);
      idle();
      chk("rol3", data_out, 8'h2D);
      run_cmd(3'd3, 0, 8'h96, 0, 0);
      run_cmd(3'd6, 4, 8'h00, 0, 0);
      idle();
      chk("asr4", data_out, 8'hF9);
      for (int i = 0; i < 16; i++) sm_bits[i] = 1'b0;
      run_cmd(3'd1, 2, 8'h00, 0, 0);
      idle();
      chk("shr2", data_out, 8'h3E);
      run_cmd(3'd3, 0, 8'h00, 0, 0);
      for (int i = 0; i < 16; i++) sm_bits[i] = 1'b1;
      run_cmd(3'd1, 9, 8'h00, 0, 0);
      idle();
      chk("shr9_sat", data_out, 8'hFF);
      for (int i = 0; i < 16; i++) sl_bits[i] = (i % 2) == 0;
      run_cmd(3'd2, 8, 8'h00, 0, 0);
      idle();
      chk("shl8_toggle", data_out, 8'hAA);
      run_cmd(3'd4, 5, 8'h00, 1, 0);
      idle();
      chk("ror5_clr_ignored", data_out, 8'h55);
      run_cmd(3'd3, 0, 8'h11, 0, 0);
      run_cmd(3'd3, 0, 8'h22, 0, 0);
      idle();
      chk("back_to_back", data_out, 8'h22);
      rand_bits();
      run_cmd(3'd3, 0, 8'hC3, 0, 0);
      run_cmd(3'd2, 6, 8'h00, 0, 3);
      run_cmd(3'd3, 0, 8'h5A, 0, 0);
      idle();
      chk("after_abort", data_out, 8'h5A);
      for (int t = 0; t < 60; t++) begin
         rand_bits();
         run_cmd(3'($urandom_range(0, 7)), $urandom_range(0, 15), 8'($urandom), bit'($urandom_range(0, 1)), 0);
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();
      repeat (2) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      chk("done_count", done_cnt, cmds);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/univ_shift_reg_n.md
Name: univ_shift_reg_n

Overview:
Parametrised universal shift register. Executes multi-bit shift and rotate commands one bit position per clock. Supports serial fill from both ends, arithmetic shift right, rotate, parallel load and clear. Commands enter through a valid/ready handshake, and a one-cycle done pulse marks completion. This is the general-purpose shifting datapath element for serial/parallel conversion and bit-manipulation blocks.

Parameters:
- WIDTH, default 8, register width in bits; legal range 2 or more.
- AW, derived localparam $clog2(WIDTH+1), width of the amt port.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- op  in  3  operation code, sampled on handshake.
- amt  in  AW  shift/rotate distance, sampled on handshake.
- data_in  in  WIDTH  parallel load value, sampled on handshake.
- sin_msb  in  1  serial fill bit for SHR, sampled on every shift edge.
- sin_lsb  in  1  serial fill bit for SHL, sampled on every shift edge.
- data_out  out  WIDTH  register contents.
- sout_lsb  out  1  equals data_out[0].
- sout_msb  out  1  equals data_out[WIDTH-1].
- done  out  1  one-cycle pulse on command completion.

Behaviour:
- Reset (reset=0, async):
  - data_out=0, done=0, cmd_ready=1, state=IDLE, remaining count=0.
  - Reset mid-command aborts the command immediately; no done pulse follows.
- Handshake:
  - A command is accepted on an edge where cmd_valid=1 and cmd_ready=1.
  - cmd_ready=1 only in IDLE.
  - cmd_valid while busy is ignored, not queued.
- Op codes:
  - 000 NOP: no change.
  - 001 SHR: logical right; MSB takes sin_msb.
  - 010 SHL: logical left; LSB takes sin_lsb.
  - 011 LOAD: data_out<=data_in.
  - 100 ROR: LSB wraps to MSB.
  - 101 ROL: MSB wraps to LSB.
  - 110 ASR: arithmetic right; MSB is replicated.
  - 111 CLR: data_out<=0.
- Distance:
  - amt is used only by ops 001, 010, 100, 101 and 110.
  - amt>WIDTH saturates to WIDTH, so any larger amt gives the same result as amt=WIDTH.
- Single-cycle commands: NOP, LOAD, CLR, and shifts with amt=0 or amt=1.
  - Result is applied at the accepting edge k.
  - done=1 during the cycle after edge k.
  - State stays IDLE, so back-to-back commands are allowed every cycle.
- Multi-cycle commands: shift with effective amt=N, where N is 2 or more.
  - One bit step at each of edges k .. k+N-1.
  - State is RUN after edge k; remaining count is loaded with N-1 and decrements on each step.
  - Return to IDLE at edge k+N-1; done=1 during the cycle after that edge.
  - cmd_ready=0 for exactly N-1 cycles.
- Serial inputs are sampled at each step edge, not latched at acceptance.
- done is registered and is never high for two consecutive cycles of the same command. Consecutive single-cycle commands produce consecutive done pulses, one per command.
- No X propagation: undefined op encodings do not exist (all 8 codes are defined).

Decomposition:
- Package univ_shift_pkg holds the op code localparams (OP_NOP ... OP_CLR) and the state encoding (ST_IDLE, ST_RUN).
- Sub-module univ_shift_step (combinational, parameter WIDTH) computes the next value for one bit step from cur, op, sin_msb and sin_lsb.
- The top module holds the FSM, remaining-count counter, amt saturation, handshake and done register.

Test Plan:
1. Reset with WIDTH=8 -> data_out=0x00, cmd_ready=1, done=0. Release reset, then LOAD 0xA5 -> data_out=0xA5 after the edge, done pulses for 1 cycle.
2. From 0xA5, ROL amt=3 -> cmd_ready low for 2 cycles, data_out sequence 0x4B, 0x96, 0x2D, done after the third edge.
3. LOAD 0x96, then ASR amt=4 -> final 0xF9. Then SHR amt=2 with sin_msb=0 -> 0x3E.
4. LOAD 0x00, SHR amt=9 with sin_msb=1 -> saturates to 8 steps, final 0xFF, cmd_ready low 7 cycles. Then SHL amt=8 with sin_lsb toggling 1,0,1,0,... -> final 0xAA.
5. Assert cmd_valid with CLR during a RUN of ROR amt=5 -> CLR ignored, ROR completes. Back-to-back LOAD 0x11, LOAD 0x22 on consecutive edges -> both accepted, 2 done pulses.
6. Assert reset asynchronously (mid-cycle) during RUN of SHL amt=6 -> data_out=0 immediately, cmd_ready=1, no done. Next command executes normally.
